// File: rtl/wall_probe_seq.sv
// -----------------------------------------------------------------------------
// wall_probe_seq
//
// Collision probe sequencer for the Pacman mover. A request latches the
// sprite's top-left pixel position and the requested direction, then walks
// PROBES points along the sprite edge it would move into, one per cycle.
// Each in-map point is turned into a maze tile address and read from the
// 1-bit-per-tile wall memory. Any wall hit, or any point that falls outside
// the playfield, makes the verdict "blocked". Latency is fixed: start
// sampled in cycle 0 gives reads in cycles 1..PROBES and done in cycle
// PROBES+2.
//
// Ports:
//   Clk       in   system clock
//   Reset_n   in   asynchronous active-low reset
//   start     in   request pulse, accepted only when idle or in the done cycle
//   dir       in   0=left, 1=up, 2=down, 3=right
//   pac_x     in   sprite top-left X (pixels)
//   pac_y     in   sprite top-left Y (pixels)
//   rom_addr  out  wall memory tile address (holds when no read is issued)
//   rom_rd    out  wall memory read strobe
//   rom_data  in   wall bit, valid one cycle after rom_rd
//   busy      out  high while probes are being issued or drained
//   done      out  one-cycle pulse, verdict valid
//   blocked   out  verdict, holds until the next done
// -----------------------------------------------------------------------------
module wall_probe_seq #(
   parameter int TILE_SHIFT = 4,
   parameter int MAP_COLS   = 40,
   parameter int MAP_W      = 640,
   parameter int MAP_H      = 480,
   parameter int SPR        = 16,
   parameter int PROBES     = 14
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        start,
   input  logic [1:0]  dir,
   input  logic [9:0]  pac_x,
   input  logic [9:0]  pac_y,
   output logic [10:0] rom_addr,
   output logic        rom_rd,
   input  logic        rom_data,
   output logic        busy,
   output logic        done,
   output logic        blocked
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic signed [11:0] SPR_S   = 12'(SPR);
   localparam logic signed [11:0] MAP_W_S = 12'(MAP_W);
   localparam logic signed [11:0] MAP_H_S = 12'(MAP_H);
   localparam logic [3:0]         LAST_K  = 4'(PROBES);

   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [1:0]  dir_q, dir_d;
   logic [3:0]  k_q, k_d;
   logic        acc_q, acc_d;
   logic        vld_q, vld_d;
   logic        blocked_q, blocked_d;
   logic [10:0] addr_q, addr_d;

   logic signed [11:0] x_s, y_s, k_s;
   logic signed [11:0] px, py;
   logic               in_map;
   logic [10:0]        col, row, row_term, probe_addr;
   logic               issue_rd;

   // ---- probe point for the current k, from the latched request ----
   always_comb begin
      x_s = $signed({2'b00, x_q});
      y_s = $signed({2'b00, y_q});
      k_s = $signed({8'd0, k_q});
      px  = x_s;
      py  = y_s;
      unique case (dir_q)
         2'd0: begin px = x_s - 12'sd1; py = y_s + k_s;   end
         2'd1: begin px = x_s + k_s;    py = y_s - 12'sd1; end
         2'd2: begin px = x_s + k_s;    py = y_s + SPR_S; end
         2'd3: begin px = x_s + SPR_S;  py = y_s + k_s;   end
      endcase
      in_map = (px >= 12'sd0) && (px < MAP_W_S) && (py >= 12'sd0) && (py < MAP_H_S);
      // Only meaningful when in_map, where px/py are non-negative.
      col = 11'($unsigned(px) >> TILE_SHIFT);
      row = 11'($unsigned(py) >> TILE_SHIFT);
   end

   // Row stride of 40 tiles is 32+8, so two shifts and an add replace a multiply.
   generate
      if (MAP_COLS == 40) begin : g_row_shift
         assign row_term = (row << 5) + (row << 3);
      end else begin : g_row_mul
         assign row_term = 11'(row * MAP_COLS);
      end
   endgenerate

   assign probe_addr = col + row_term;
   assign issue_rd   = (state_q == S_ISSUE) && in_map;

   // Address is held from the last real read so the memory bus stays quiet
   // during skipped (out-of-map) probes.
   assign rom_rd   = issue_rd;
   assign rom_addr = issue_rd ? probe_addr : addr_q;
   assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);
   assign blocked  = blocked_q;

   // ---- next state ----
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dir_d     = dir_q;
      k_d       = k_q;
      blocked_d = blocked_q;
      addr_d    = rom_addr;
      // Read data returns one cycle after the strobe; vld marks those cycles.
      vld_d     = issue_rd;
      acc_d     = acc_q | (vld_q & rom_data);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = pac_x;
               y_d     = pac_y;
               dir_d   = dir;
               k_d     = 4'd1;
               acc_d   = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!in_map) begin
               acc_d = 1'b1;
            end
            if (k_q == LAST_K) begin
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         S_DRAIN: begin
            // Last probe's data is folded in here, so publish the full result.
            blocked_d = acc_d;
            state_d   = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               x_d     = pac_x;
               y_d     = pac_y;
               dir_d   = dir;
               k_d     = 4'd1;
               acc_d   = 1'b0;
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // ---- registers ----
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         dir_q     <= '0;
         k_q       <= '0;
         acc_q     <= 1'b0;
         vld_q     <= 1'b0;
         blocked_q <= 1'b0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_q     <= dir_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         vld_q     <= vld_d;
         blocked_q <= blocked_d;
         addr_q    <= addr_d;
      end
   end

endmodule
